sprite_line_fetcher: RTL and testbench

Controller that sequences the 4-bit palette-index sprite ROM (181x256 image, 1-cycle registered read latency) for scanline rendering. During display of line y it prefetches the sprite row for line y+1 into one bank of a double-buffered line buffer. It serves per-pixel palette indices to the colour mapper from the other bank, so the ROM is never read on the pixel-critical path.

---
 rtl/sprite_line_fetcher.sv | 168 ++++++++++++++++
 tb/tb_sprite_line_fetcher.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_fetcher.sv
// Double-buffered sprite scanline prefetcher: fills one line bank from the registered sprite ROM
// while the other bank serves per-pixel palette indices to the colour mapper.
module sprite_line_fetcher #(
    parameter int unsigned SPRITE_W       = 181,
    parameter int unsigned SPRITE_H       = 256,
    parameter int unsigned ADDR_W         = 17,
    parameter int unsigned IDX_W          = 4,
    parameter bit          TRANSPARENT_EN = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              line_start,
    input  logic [9:0]        next_y,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic [9:0]        DrawX,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_idx,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              pix_valid,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int unsigned COL_W = $clog2(SPRITE_W);

    localparam logic [COL_W-1:0]  ColLast   = COL_W'(SPRITE_W - 1);
    localparam logic [10:0]       SpriteW11 = 11'(SPRITE_W);
    localparam logic [10:0]       SpriteH11 = 11'(SPRITE_H);
    localparam logic [ADDR_W-1:0] SpriteWA  = ADDR_W'(SPRITE_W);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e             state_q, state_d;
    logic               disp_bank_q, disp_bank_d;
    logic [1:0]         hit_q, hit_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               wr_en_q, wr_en_d;
    logic [COL_W-1:0]   wr_col_q, wr_col_d;
    logic               skip_q, skip_d;
    logic               overrun_q, overrun_d;
    logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
    logic               pix_valid_q, pix_valid_d;

    logic [IDX_W-1:0]   buf_q [2][SPRITE_W];

    logic [10:0]        row;
    logic               row_ok;
    logic               mem_we;
    logic               wr_bank;
    logic [10:0]        dx;
    logic               disp_hit;
    logic [COL_W-1:0]   rd_col;
    logic [IDX_W-1:0]   rd_idx;

    assign wr_bank = ~disp_bank_q;

    // Fetch sequencing and line_start handling; line_start overrides whatever the FSM was doing.
    always_comb begin
        state_d     = state_q;
        disp_bank_d = disp_bank_q;
        hit_d       = hit_q;
        base_d      = base_q;
        col_d       = col_q;
        wr_en_d     = 1'b0;
        wr_col_d    = wr_col_q;
        skip_d      = 1'b0;
        overrun_d   = overrun_q;
        mem_we      = wr_en_q;

        row    = {1'b0, next_y} - {1'b0, sprite_y};
        row_ok = !row[10] && (row < SpriteH11);

        unique case (state_q)
            StFetch: begin
                wr_en_d  = 1'b1;
                wr_col_d = col_q;
                col_d    = col_q + 1'b1;
                if (col_q == ColLast) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                hit_d[wr_bank] = 1'b1;
                state_d        = StIdle;
            end
            default: ;
        endcase

        if (line_start) begin
            disp_bank_d        = ~disp_bank_q;
            mem_we             = 1'b0;
            wr_en_d            = 1'b0;
            // Old display bank becomes the new fetch bank; its contents are about to be stale.
            hit_d[disp_bank_q] = 1'b0;
            if (state_q != StIdle) begin
                overrun_d      = 1'b1;
                hit_d[wr_bank] = 1'b0;
            end
            if (row_ok) begin
                base_d  = ADDR_W'(row) * SpriteWA;
                col_d   = '0;
                state_d = StFetch;
            end else begin
                state_d = StIdle;
                skip_d  = 1'b1;
            end
        end

        if (Reset) begin
            mem_we = 1'b0;
        end
    end

    // Display read: the display bank is never the fetch bank, so no port collision.
    always_comb begin
        dx          = {1'b0, DrawX} - {1'b0, sprite_x};
        disp_hit    = hit_q[disp_bank_q] && !dx[10] && (dx < SpriteW11);
        rd_col      = disp_hit ? dx[COL_W-1:0] : '0;
        rd_idx      = buf_q[disp_bank_q][rd_col];
        pix_idx_d   = disp_hit ? rd_idx : '0;
        pix_valid_d = disp_hit && !(TRANSPARENT_EN && (rd_idx == '0));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            disp_bank_q <= 1'b0;
            hit_q       <= '0;
            base_q      <= '0;
            col_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_col_q    <= '0;
            skip_q      <= 1'b0;
            overrun_q   <= 1'b0;
            pix_idx_q   <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            disp_bank_q <= disp_bank_d;
            hit_q       <= hit_d;
            base_q      <= base_d;
            col_q       <= col_d;
            wr_en_q     <= wr_en_d;
            wr_col_q    <= wr_col_d;
            skip_q      <= skip_d;
            overrun_q   <= overrun_d;
            pix_idx_q   <= pix_idx_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            buf_q[wr_bank][wr_col_q] <= rom_idx;
        end
    end

    assign rom_addr  = (state_q == StFetch) ? (base_q + ADDR_W'(col_q)) : '0;
    assign busy      = (state_q != StIdle);
    assign done      = skip_q || ((state_q == StDrain) && !line_start);
    assign overrun   = overrun_q;
    assign pix_idx   = pix_idx_q;
    assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher: table-driven display checks plus fetch/overrun/reset
// sequences against a registered ROM model.
module tb_sprite_line_fetcher;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        line_start;
    logic [9:0]  next_y, sprite_x, sprite_y, DrawX;
    logic [16:0] rom_addr;
    logic [3:0]  rom_idx, pix_idx;
    logic        pix_valid, busy, done, overrun;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int sx;
        int dx;
        int eidx;
        int evalid;
    } vec_t;

    vec_t tbl[13];

    always #5 Clk = ~Clk;

    sprite_line_fetcher dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .line_start (line_start),
        .next_y     (next_y),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .DrawX      (DrawX),
        .rom_addr   (rom_addr),
        .rom_idx    (rom_idx),
        .pix_idx    (pix_idx),
        .pix_valid  (pix_valid),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    // Sprite image: never zero except a single transparent pixel at row 20, col 10.
    function automatic logic [3:0] model(input int a);
        if (a == 20 * 181 + 10) return 4'd0;
        return 4'((a % 15) + 1);
    endfunction

    always @(posedge Clk) rom_idx <= model(int'(rom_addr));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_line(input int ny);
        next_y     = 10'(ny);
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    task automatic show(input string nm, input int sx, input int dx, input int eidx,
                        input int ev);
        sprite_x = 10'(sx);
        DrawX    = 10'(dx);
        step();
        check({nm, "_idx"}, 32'(pix_idx), 32'(eidx));
        check({nm, "_valid"}, 32'(pix_valid), 32'(ev));
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            show($sformatf("tbl%0d", i), tbl[i].sx, tbl[i].dx, tbl[i].eidx, tbl[i].evalid);
        end
    endtask

    // Walks a fetch already in progress at column 0, checking every address and busy.
    task automatic walk_fetch(input string nm, input int base);
        int aerr;
        int dcnt;
        aerr = 0;
        dcnt = 0;
        for (int i = 0; i < 181; i++) begin
            if (rom_addr !== 17'(base + i) || busy !== 1'b1) aerr++;
            if (done) dcnt++;
            step();
        end
        check({nm, "_addr_seq_errs"}, 32'(aerr), 0);
        check({nm, "_early_done"}, 32'(dcnt), 0);
        check({nm, "_drain_done"}, 32'(done), 1);
        check({nm, "_drain_busy"}, 32'(busy), 1);
        step();
        check({nm, "_idle_busy"}, 32'(busy), 0);
        check({nm, "_idle_done"}, 32'(done), 0);
    endtask

    task automatic sweep_invalid(input string nm, input int sx);
        int cnt;
        cnt      = 0;
        sprite_x = 10'(sx);
        for (int x = 0; x < 640; x++) begin
            DrawX = 10'(x);
            step();
            if (pix_valid !== 1'b0) cnt++;
        end
        check(nm, 32'(cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k;

        // Table A: row 5 (base 905), sprite_x=200.
        tbl[0]  = '{200, 200, int'(model(905)), 1};
        tbl[1]  = '{200, 380, int'(model(1085)), 1};
        tbl[2]  = '{200, 381, 0, 0};
        tbl[3]  = '{200, 199, 0, 0};
        tbl[4]  = '{200, 0, 0, 0};
        tbl[5]  = '{200, 290, int'(model(995)), 1};
        // Table B: row 6 (base 1086), sprite_x=500 partly off the right edge.
        tbl[6]  = '{500, 680, int'(model(1266)), 1};
        tbl[7]  = '{500, 681, 0, 0};
        tbl[8]  = '{500, 499, 0, 0};
        tbl[9]  = '{500, 500, int'(model(1086)), 1};
        // Table C: row 20 (base 3620), transparent pixel at col 10.
        tbl[10] = '{0, 10, 0, 0};
        tbl[11] = '{0, 9, int'(model(3629)), 1};
        tbl[12] = '{0, 11, int'(model(3631)), 1};

        Reset      = 1'b1;
        line_start = 1'b0;
        next_y     = '0;
        sprite_x   = '0;
        sprite_y   = '0;
        DrawX      = '0;
        step();
        step();
        Reset = 1'b0;
        check("rst_pix_idx", 32'(pix_idx), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);

        // Full fetch of row 5 into bank 0.
        sprite_y = 10'd100;
        sprite_x = 10'd200;
        pulse_line(105);
        walk_fetch("fetch5", 905);

        // Out-of-range row swaps banks without fetching.
        pulse_line(50);
        check("skip_done", 32'(done), 1);
        check("skip_busy", 32'(busy), 0);
        check("skip_rom_addr", 32'(rom_addr), 0);
        show("px203", 200, 203, int'(model(908)), int'(model(908) != 0));
        check("skip_done_once", 32'(done), 0);
        run_table(0, 5);

        // Misses above and below the sprite leave nothing displayable.
        pulse_line(356);
        check("miss356_done", 32'(done), 1);
        check("miss356_addr", 32'(rom_addr), 0);
        step();
        pulse_line(99);
        check("miss99_done", 32'(done), 1);
        check("miss99_busy", 32'(busy), 0);
        sweep_invalid("miss_line_valid_cnt", 200);

        // Overrun: restart 50 cycles into a fetch.
        pulse_line(105);
        repeat (49) step();
        check("pre_ovr_busy", 32'(busy), 1);
        check("pre_ovr_flag", 32'(overrun), 0);
        pulse_line(106);
        check("ovr_flag", 32'(overrun), 1);
        walk_fetch("fetch6", 1086);
        check("ovr_sticky", 32'(overrun), 1);
        show("aborted_bank", 200, 203, 0, 0);
        pulse_line(50);
        show("row6_px203", 200, 203, int'(model(1089)), 1);
        run_table(6, 9);

        // Transparent pixel in row 20.
        sprite_x = '0;
        pulse_line(120);
        k = 0;
        while (!done && k < 400) begin
            step();
            k++;
        end
        check("row20_done", 32'(done), 1);
        step();
        pulse_line(50);
        run_table(10, 12);

        // Reset mid-fetch.
        pulse_line(105);
        repeat (20) step();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_done", 32'(done), 0);
        check("mrst_overrun", 32'(overrun), 0);
        check("mrst_rom_addr", 32'(rom_addr), 0);
        check("mrst_pix_idx", 32'(pix_idx), 0);
        check("mrst_pix_valid", 32'(pix_valid), 0);
        step();
        check("mrst_still_idle", 32'(busy), 0);
        sweep_invalid("mrst_line_valid_cnt", 200);
        pulse_line(50);
        sweep_invalid("mrst_swap_valid_cnt", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
